// File: rtl/keypad_scan_ctrl.sv
// Keypad column-scan controller: drives the active-low column lines,
// synchronizes the rows and debounces press/release. It emits one key event
// per physical press. The external 2-bit scan counter is advanced only through
// scan_counter_en, so the column freezes while a key is being debounced or
// is held.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  input  logic [1:0] encoded_cols,
  output logic       scan_counter_en,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   deb_q, deb_d, deb_inc;
  logic [3:0]      rows_s1_q, rows_s_q;
  logic [1:0]      row_idx_q, row_idx_d, col_idx_q, col_idx_d, low_idx;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            scan_en_q, scan_en_d;
  logic            dwell_end, accept;

  // Column drive follows the counter directly; no added latency.
  assign cols_n = ~(4'b0001 << encoded_cols);

  assign dwell_end = (dwell_q == DWELL_LAST);
  assign deb_inc   = deb_q + CW'(1);

  assign scan_counter_en = scan_en_q;
  assign key_code        = key_code_q;
  assign key_valid       = key_valid_q;
  assign key_held        = key_held_q;

  // Lowest-index low row wins when several rows are pressed at once.
  always_comb begin
    casez (rows_s_q)
      4'b???0: low_idx = 2'd0;
      4'b??01: low_idx = 2'd1;
      4'b?011: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  end

  // Next-state logic: dwell timing, scan/debounce/held sequencing.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_end ? '0 : dwell_q + DW'(1);
    deb_d       = deb_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    scan_en_d   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      SCAN: if (dwell_end) begin
        if (&rows_s_q) begin
          scan_en_d = 1'b1;
        end else begin
          row_idx_d = low_idx;
          col_idx_d = encoded_cols;
          if (DEBOUNCE_CNT == 1) begin
            accept = 1'b1;
          end else begin
            deb_d   = CW'(1);
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: if (dwell_end) begin
        if (!rows_s_q[row_idx_q]) begin
          if (deb_inc == DEB_LAST) accept = 1'b1;
          else                     deb_d  = deb_inc;
        end else begin
          // Bounce: back to scanning on the same column, nothing emitted.
          deb_d   = '0;
          state_d = SCAN;
        end
      end
      HELD: if (dwell_end) begin
        if (rows_s_q[row_idx_q]) begin
          if (deb_inc == DEB_LAST) begin
            deb_d      = '0;
            key_held_d = 1'b0;
            scan_en_d  = 1'b1;
            state_d    = SCAN;
          end else begin
            deb_d = deb_inc;
          end
        end else begin
          // A low glitch during release restarts the release count.
          deb_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
    if (accept) begin
      key_code_d  = {row_idx_d, col_idx_d};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      deb_d       = '0;
      state_d     = HELD;
    end
  end

  // State, counters, row synchronizer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      deb_q       <= '0;
      rows_s1_q   <= 4'hF;
      rows_s_q    <= 4'hF;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      scan_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      rows_s1_q   <= rows_n;
      rows_s_q    <= rows_s1_q;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      scan_en_q   <= scan_en_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: models the external scan counter and a 4x4
// switch matrix; key events are scoreboarded with their expected cycle.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows_n;
  logic [1:0]  enc;
  logic        en;
  logic [3:0]  cols_n, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c closed

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .reset(reset), .rows_n(rows_n), .encoded_cols(enc),
    .scan_counter_en(en), .cols_n(cols_n), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its row low when its column is driven.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  // Cycle counter (tracks the dwell phase) and the external scan counter.
  int tcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt <= 0;
      enc  <= 2'd0;
    end else begin
      tcnt <= tcnt + 1;
      if (en) enc <= enc + 2'd1;
    end
  end

  typedef struct { logic [3:0] code; int cyc; } ev_t;
  ev_t sbq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, tcnt);
    end
  endtask

  // Scoreboard: every key_valid must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (reset && key_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key_valid got code=%0h exp no event (cycle %0d)", key_code, tcnt);
      end else begin
        e = sbq.pop_front();
        chk("key_code", key_code, e.code);
        chk("key_valid_cycle", tcnt, e.cyc);
      end
    end
  end

  task automatic wait_until(input int target);
    while (tcnt < target) @(negedge clk);
  endtask

  task automatic wait_phase1(output int t);
    @(negedge clk);
    while (tcnt % 4 != 1) @(negedge clk);
    t = tcnt;
  endtask

  // First cycle of a dwell on column c.
  task automatic wait_col_start(input int c, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!(tcnt % 4 == 1 && enc == 2'(c)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("col_reach_in_budget", n < 200, 1);
    t = tcnt;
  endtask

  // Press at dwell start: sampled 2 cycles later, accepted on the 3rd sample.
  task automatic press_accept(input int r, input int c, input logic [3:0] code, output int t);
    wait_col_start(c, t);
    pressed[r*4+c] = 1'b1;
    sbq.push_back('{code, t + 11});
    wait_until(t + 10);
    chk("held_before_accept", key_held, 0);
    wait_until(t + 11);
    chk("held_on_accept", key_held, 1);
    chk("valid_on_accept", key_valid, 1);
  endtask

  task automatic release_check(input int r);
    wait_until(r + 10);
    chk("held_before_release", key_held, 1);
    chk("no_scan_before_release", en, 0);
    wait_until(r + 11);
    chk("held_cleared", key_held, 0);
    chk("scan_en_on_release", en, 1);
  endtask

  typedef struct { int row; int col; logic [3:0] code; } vec_t;
  vec_t vecs[4];

  initial begin
    int t, r, en_seen;
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t, r, en_seen;
    vecs[0] = '{2, 1, 4'b1001};
    vecs[1] = '{0, 0, 4'b0000};
    vecs[2] = '{3, 3, 4'b1111};
    vecs[3] = '{1, 2, 4'b0110};

    // Reset values
    #1 reset = 1'b0;
    #2;
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_scan_en", en, 0);
    chk("rst_cols_n", cols_n, 4'hE);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle scan: one advance strobe every 4th cycle, columns E,D,B,7,...
    en_seen = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (en) en_seen++;
      if (tcnt % 4 == 0 || i < 6)
        chk("idle_scan_en", en, (tcnt % 4 == 0));
      if (tcnt % 4 == 1)
        chk("idle_cols_n", cols_n, 4'hF ^ (4'b0001 << enc));
      if (tcnt == 5)  chk("idle_col1", cols_n, 4'hD);
      if (tcnt == 9)  chk("idle_col2", cols_n, 4'hB);
      if (tcnt == 13) chk("idle_col3", cols_n, 4'h7);
      if (tcnt == 17) chk("idle_col0_wrap", cols_n, 4'hE);
    end
    chk("idle_scan_pulses", en_seen, 8);

    // Single-key vectors: accept timing/code, frozen column, release timing.
    for (int i = 0; i < 4; i++) begin
      press_accept(vecs[i].row, vecs[i].col, vecs[i].code, t);
      en_seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (en) en_seen++;
        if (key_valid) en_seen += 100;
      end
      chk("held_no_scan_no_revalid", en_seen, 0);
      chk("held_code", key_code, vecs[i].code);
      wait_phase1(r);
      pressed = '0;
      release_check(r);
      @(negedge clk);
      chk("code_kept_after_release", key_code, vecs[i].code);
      chk("events_consumed", sbq.size(), 0);
    end

    // Bounce: row 2 low for one dwell at column 3.
    wait_col_start(3, t);
    pressed[2*4+3] = 1'b1;
    wait_until(t + 3);
    chk("bounce_detect_freezes", en, 0);
    wait_until(t + 4);
    pressed = '0;
    en_seen = 0;
    while (tcnt < t + 10) begin
      @(negedge clk);
      if (en) en_seen++;
    end
    chk("bounce_no_advance", en_seen, 0);
    chk("bounce_col_kept", enc, 3);
    chk("bounce_held", key_held, 0);
    wait_until(t + 11);
    chk("bounce_rescan_en", en, 1);

    // Release with a low glitch on the 2nd release dwell.
    press_accept(1, 1, 4'b0101, t);
    wait_phase1(r);
    pressed = '0;
    wait_until(r + 4);
    pressed[1*4+1] = 1'b1;
    wait_until(r + 8);
    pressed = '0;
    wait_until(r + 18);
    chk("glitch_still_held", key_held, 1);
    wait_until(r + 19);
    chk("glitch_release_held", key_held, 0);
    chk("glitch_release_en", en, 1);

    // Multi-key: rows 1 and 3 at column 0 -> row 1 wins; later row 0 ignored.
    press_accept(1, 0, 4'b0100, t);
    pressed[3*4+0] = 1'b1;
    wait_phase1(r);
    pressed[0*4+0] = 1'b1;
    repeat (16) @(negedge clk);
    chk("multi_code_kept", key_code, 4'b0100);
    chk("multi_still_held", key_held, 1);
    wait_phase1(r);
    pressed = '0;
    release_check(r);
    chk("multi_events_consumed", sbq.size(), 0);

    // Asynchronous reset in the middle of HELD.
    press_accept(2, 2, 4'b1010, t);
    wait_until(t + 14);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_key_code", key_code, 0);
    chk("mid_rst_key_valid", key_valid, 0);
    chk("mid_rst_key_held", key_held, 0);
    chk("mid_rst_scan_en", en, 0);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_until(3);
    chk("post_rst_no_en", en, 0);
    chk("post_rst_col", cols_n, 4'hE);
    wait_until(4);
    chk("post_rst_scan_en", en, 1);
    wait_until(5);
    chk("post_rst_advance", cols_n, 4'hD);
    chk("final_events_consumed", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
